conv_feeder: RTL

Single-clock stream source that drives the convolution core's load-side interface: `set_wgt`/`wgt`, `start_conv`, `set_ifm`/`ifm`. For every (output channel, input channel) pair it does four things:
- reads one KERNEL_SIZE×KERNEL_SIZE kernel from weight memory and packs it into the core's weight vector;
- pulses `start_conv`;
- streams the matching IFM channel pixel by pixel from IFM memory;
- waits for the core to drain.

It sits between the on-chip weight/IFM SRAMs and the accelerator top, on the same `clk1` domain as the PE array.

---
 rtl/conv_feeder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_feeder.sv
// Kernel/IFM stream source for the conv core. Per (co,ci) pair: load kernel, pulse start_conv, stream IFM, drain.
// Fixed 1-cycle memory latency, no backpressure; FEEDER_WAIT_END_EN makes the drain wait on end_conv.
module conv_feeder #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int IFM_WIDTH    = 8,
  parameter int IFM_SIZE     = 9,
  parameter int KERNEL_SIZE  = 3,
  parameter int CI           = 3,
  parameter int CO           = 4,
  parameter int GAP_CYCLES   = 16,
  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE,
  localparam int NPIX = IFM_SIZE * IFM_SIZE,
  localparam int WA   = (CO * CI * KK > 1) ? $clog2(CO * CI * KK) : 1,
  localparam int IA   = (CI * NPIX > 1) ? $clog2(CI * NPIX) : 1
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       wgt_rd,
  output logic [WA-1:0]              wgt_addr,
  input  logic [WEIGHT_WIDTH-1:0]    wgt_rdata,
  output logic                       ifm_rd,
  output logic [IA-1:0]              ifm_addr,
  input  logic [IFM_WIDTH-1:0]       ifm_rdata,
  output logic                       set_wgt,
  output logic [KK*WEIGHT_WIDTH-1:0] wgt,
  output logic                       start_conv,
  output logic                       set_ifm,
  output logic [IFM_WIDTH-1:0]       ifm,
  input  logic                       end_conv
);

  localparam int WGT_W = KK * WEIGHT_WIDTH;
  localparam int KW    = (KK > 1) ? $clog2(KK) : 1;
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CIW   = (CI > 1) ? $clog2(CI) : 1;
  localparam int COW   = (CO > 1) ? $clog2(CO) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WLOAD, S_WCAP, S_WSET, S_START, S_IFM, S_ITAIL, S_GAP, S_DONE
  } state_t;

  state_t            r_state;
  logic [COW-1:0]    r_co;
  logic [CIW-1:0]    r_ci;
  logic [KW-1:0]     r_k;
  logic [PW-1:0]     r_pix;
  logic              r_busy;
  logic              r_done;
  logic              r_wgt_rd;
  logic [WA-1:0]     r_wgt_addr;
  logic              r_ifm_rd;
  logic [IA-1:0]     r_ifm_addr;
  logic              r_set_wgt;
  logic              r_start_conv;
  logic              r_wgt_rd_d;
  logic              r_ifm_rd_d;
  logic              r_set_ifm;
  logic [WGT_W-1:0]  r_wgt;
  logic [IFM_WIDTH-1:0] r_ifm;
  logic              w_gap_exit;

`ifdef FEEDER_WAIT_END_EN
  assign w_gap_exit = end_conv;
`else
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GW-1:0] r_gap;
  logic          w_unused_end_conv;

  assign w_unused_end_conv = end_conv;
  assign w_gap_exit        = (r_gap == GW'(GAP_CYCLES - 1));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      r_gap <= '0;
    else if (r_state == S_GAP && !w_gap_exit)
      r_gap <= r_gap + GW'(1);
    else
      r_gap <= '0;
  end
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_co         <= '0;
      r_ci         <= '0;
      r_k          <= '0;
      r_pix        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wgt_rd     <= 1'b0;
      r_wgt_addr   <= '0;
      r_ifm_rd     <= 1'b0;
      r_ifm_addr   <= '0;
      r_set_wgt    <= 1'b0;
      r_start_conv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_co       <= '0;
            r_ci       <= '0;
            r_k        <= '0;
            r_busy     <= 1'b1;
            r_wgt_rd   <= 1'b1;
            r_wgt_addr <= '0;
            r_state    <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (r_k == KW'(KK - 1)) begin
            r_wgt_rd <= 1'b0;
            r_state  <= S_WCAP;
          end else begin
            r_k        <= r_k + KW'(1);
            r_wgt_addr <= r_wgt_addr + WA'(1);
          end
        end
        S_WCAP: begin
          r_set_wgt <= 1'b1;
          r_state   <= S_WSET;
        end
        S_WSET: begin
          r_set_wgt    <= 1'b0;
          r_start_conv <= 1'b1;
          r_state      <= S_START;
        end
        // Channels are stored back to back, so a new ci continues from the last pixel address.
        S_START: begin
          r_start_conv <= 1'b0;
          r_ifm_rd     <= 1'b1;
          r_pix        <= '0;
          r_ifm_addr   <= (r_ci == '0) ? '0 : r_ifm_addr + IA'(1);
          r_state      <= S_IFM;
        end
        S_IFM: begin
          if (r_pix == PW'(NPIX - 1)) begin
            r_ifm_rd <= 1'b0;
            r_state  <= S_ITAIL;
          end else begin
            r_pix      <= r_pix + PW'(1);
            r_ifm_addr <= r_ifm_addr + IA'(1);
          end
        end
        S_ITAIL: r_state <= S_GAP;
        // Kernels are also contiguous in (co,ci) order, so the weight address just keeps counting.
        S_GAP: begin
          if (w_gap_exit) begin
            if (r_ci != CIW'(CI - 1)) begin
              r_ci       <= r_ci + CIW'(1);
              r_k        <= '0;
              r_wgt_rd   <= 1'b1;
              r_wgt_addr <= r_wgt_addr + WA'(1);
              r_state    <= S_WLOAD;
            end else if (r_co != COW'(CO - 1)) begin
              r_ci       <= '0;
              r_co       <= r_co + COW'(1);
              r_k        <= '0;
              r_wgt_rd   <= 1'b1;
              r_wgt_addr <= r_wgt_addr + WA'(1);
              r_state    <= S_WLOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data lands one cycle after the strobe; set_ifm is aligned with the registered pixel.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wgt_rd_d <= 1'b0;
      r_ifm_rd_d <= 1'b0;
      r_set_ifm  <= 1'b0;
      r_wgt      <= '0;
      r_ifm      <= '0;
    end else begin
      r_wgt_rd_d <= r_wgt_rd;
      r_ifm_rd_d <= r_ifm_rd;
      r_set_ifm  <= r_ifm_rd_d;
      if (r_wgt_rd_d)
        r_wgt <= (r_wgt << WEIGHT_WIDTH) | WGT_W'(wgt_rdata);
      if (r_ifm_rd_d)
        r_ifm <= ifm_rdata;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign wgt_rd     = r_wgt_rd;
  assign wgt_addr   = r_wgt_addr;
  assign ifm_rd     = r_ifm_rd;
  assign ifm_addr   = r_ifm_addr;
  assign set_wgt    = r_set_wgt;
  assign wgt        = r_wgt;
  assign start_conv = r_start_conv;
  assign set_ifm    = r_set_ifm;
  assign ifm        = r_ifm;

endmodule
